sweep_sequencer: RTL

- Sequences the shared ADC/DAC task trigger to run a cyclic staircase sweep (cyclic voltammetry) between a start and a vertex code.
- Each sweep point runs three steps: a DAC update task (mode=1), a programmable settle wait, then an ADC sample task (mode=0).
- Sits between the register bank / host control and the task trigger. Drives mode and trigger_task, and consumes done_task.

---
 rtl/sweep_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sweep_sequencer.sv
// sweep_sequencer: runs a cyclic staircase sweep between a start and a vertex code.
// Each point does a DAC task, an optional settle wait, then an ADC task, all through
// the shared task trigger (mode + trigger_task, answered by done_task).
module sweep_sequencer #(
    parameter int unsigned DW = 16,
    parameter int unsigned SW = 16,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] cfg_v_start,
    input  logic [DW-1:0] cfg_v_vertex,
    input  logic [DW-1:0] cfg_step,
    input  logic [CW-1:0] cfg_cycles,
    input  logic [SW-1:0] cfg_settle,
    input  logic          done_task,
    output logic          mode,
    output logic          trigger_task,
    output logic [DW-1:0] dac_code,
    output logic          direction,
    output logic          sample_valid,
    output logic [15:0]   sample_index,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          aborted
);

    typedef enum logic [3:0] {
        StIdle, StLoad, StDacTrig, StDacWait, StSettle,
        StAdcTrig, StAdcWait, StNext, StFinish
    } state_e;

    state_e        state_q;
    logic [DW-1:0] v_start_q;
    logic [DW-1:0] v_vertex_q;
    logic [DW-1:0] step_q;
    logic [CW-1:0] cycles_q;
    logic [SW-1:0] settle_q;
    logic [CW-1:0] cycle_cnt_q;
    logic [SW-1:0] settle_cnt_q;
    logic [15:0]   point_cnt_q;

    logic [DW:0]   rise_sum;
    logic [DW:0]   fall_lim;
    logic          rise_hit;
    logic          fall_hit;
    logic          cycles_done;

    // Next-point arithmetic, one bit wider so code+step and start+step cannot wrap.
    always_comb begin
        rise_sum    = {1'b0, dac_code} + {1'b0, step_q};
        fall_lim    = {1'b0, v_start_q} + {1'b0, step_q};
        rise_hit    = (rise_sum >= {1'b0, v_vertex_q});
        // Landing on (or below) start ends the falling leg; that start point is then
        // measured once and doubles as the first point of the next cycle.
        fall_hit    = ({1'b0, dac_code} <= fall_lim);
        cycles_done = (cycle_cnt_q == cycles_q);
    end

    // Sequencer FSM; all outputs are registered and set on entry to the state that owns them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            v_start_q    <= '0;
            v_vertex_q   <= '0;
            step_q       <= '0;
            cycles_q     <= '0;
            settle_q     <= '0;
            cycle_cnt_q  <= '0;
            settle_cnt_q <= '0;
            point_cnt_q  <= '0;
            mode         <= 1'b0;
            trigger_task <= 1'b0;
            dac_code     <= '0;
            direction    <= 1'b0;
            sample_valid <= 1'b0;
            sample_index <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            trigger_task <= 1'b0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            aborted      <= 1'b0;

            if (abort && state_q != StIdle) begin
                state_q <= StIdle;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            if (cfg_v_vertex <= cfg_v_start) begin
                                err <= 1'b1;
                            end else begin
                                state_q <= StLoad;
                                busy    <= 1'b1;
                            end
                        end
                    end
                    StLoad: begin
                        v_start_q    <= cfg_v_start;
                        v_vertex_q   <= cfg_v_vertex;
                        step_q       <= (cfg_step == '0) ? DW'(1) : cfg_step;
                        cycles_q     <= (cfg_cycles == '0) ? CW'(1) : cfg_cycles;
                        settle_q     <= cfg_settle;
                        dac_code     <= cfg_v_start;
                        direction    <= 1'b0;
                        cycle_cnt_q  <= '0;
                        point_cnt_q  <= '0;
                        sample_index <= '0;
                        mode         <= 1'b1;
                        trigger_task <= 1'b1;
                        state_q      <= StDacTrig;
                    end
                    StDacTrig: begin
                        state_q <= StDacWait;
                    end
                    StDacWait: begin
                        if (done_task) begin
                            if (settle_q != '0) begin
                                settle_cnt_q <= '0;
                                state_q      <= StSettle;
                            end else begin
                                mode         <= 1'b0;
                                trigger_task <= 1'b1;
                                state_q      <= StAdcTrig;
                            end
                        end
                    end
                    StSettle: begin
                        if (settle_cnt_q == settle_q - SW'(1)) begin
                            mode         <= 1'b0;
                            trigger_task <= 1'b1;
                            state_q      <= StAdcTrig;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + SW'(1);
                        end
                    end
                    StAdcTrig: begin
                        state_q <= StAdcWait;
                    end
                    StAdcWait: begin
                        if (done_task) begin
                            sample_valid <= 1'b1;
                            sample_index <= point_cnt_q;
                            point_cnt_q  <= point_cnt_q + 16'd1;
                            state_q      <= StNext;
                        end
                    end
                    StNext: begin
                        // Rising with the last cycle counted means the final start point was just measured.
                        if (!direction && cycles_done) begin
                            done    <= 1'b1;
                            state_q <= StFinish;
                        end else begin
                            mode         <= 1'b1;
                            trigger_task <= 1'b1;
                            state_q      <= StDacTrig;
                            if (!direction) begin
                                if (rise_hit) begin
                                    dac_code  <= v_vertex_q;
                                    direction <= 1'b1;
                                end else begin
                                    dac_code <= rise_sum[DW-1:0];
                                end
                            end else if (fall_hit) begin
                                dac_code    <= v_start_q;
                                direction   <= 1'b0;
                                cycle_cnt_q <= cycle_cnt_q + CW'(1);
                            end else begin
                                dac_code <= dac_code - step_q;
                            end
                        end
                    end
                    StFinish: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
